// File: rtl/sm_clk_ctrl_pkg.sv
// sm_clk_pkg: shared state encoding and mode-switch codes for the CPU clock controller.
package sm_clk_pkg;

  typedef enum logic [1:0] {
    S_STOP,
    S_RUN,
    S_STEP
  } state_t;

  localparam logic [1:0] MODE_STOP = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  // The prescaler only advances while a clock period is being generated.
  function automatic logic is_counting(state_t s);
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/sm_clk_ctrl_if.sv
// sm_clk_ctrl_if: board-side switches/button and CPU-side clock outputs of the clock controller.
interface sm_clk_ctrl_if
  import sm_clk_pkg::*;
#(
  parameter int DIV_W = 4
);
  logic [DIV_W-1:0] devide;
  logic [1:0]       mode;
  logic             stepBtn;
  logic             clkOut;
  logic             riseStb;
  logic [31:0]      tickCount;
  logic             busy;

  modport master (
    output devide, mode, stepBtn,
    input  clkOut, riseStb, tickCount, busy
  );

  modport slave (
    input  devide, mode, stepBtn,
    output clkOut, riseStb, tickCount, busy
  );
endinterface

// File: rtl/sm_clk_ctrl_deb_filter.sv
// sm_deb_filter: synchronises a bouncing push-button, accepts a new level only after it has
// been stable for DEB_CNT cycles, and emits a one-cycle pulse when the accepted level rises.
module sm_deb_filter #(
  parameter int DEB_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise_pulse
);
  localparam int CW = $clog2(DEB_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

  logic          btn_meta;
  logic          btn_sync;
  logic          level;
  logic [CW-1:0] stable_cnt;
  logic          flip;

  assign flip = (btn_sync != level) && (stable_cnt == CNT_LAST);

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Count consecutive disagreeing cycles; the DEB_CNT-th one flips the accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= flip && btn_sync;
      if (btn_sync == level) begin
        stable_cnt <= '0;
      end else if (flip) begin
        stable_cnt <= '0;
        level      <= btn_sync;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/sm_clk_ctrl.sv
// sm_clk_ctrl: parametrised CPU clock controller with stop, free-run and single-step modes.
// Half-period is 2**(SHIFT+divA) clkIn cycles; ratio changes only land on a falling boundary.
module sm_clk_ctrl
  import sm_clk_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int SHIFT   = 16,
  parameter int DIV_W   = 4,
  parameter int DEB_CNT = 50000
) (
  input logic          clkIn,
  input logic          rst,
  sm_clk_ctrl_if.slave bus
);

  if (SHIFT + (2 ** DIV_W) - 1 >= CNT_W) begin : g_param_check
    $error("sm_clk_ctrl: SHIFT + 2**DIV_W - 1 must be below CNT_W");
  end

  logic [DIV_W-1:0] dev_meta;
  logic [DIV_W-1:0] dev_sync;
  logic [1:0]       mode_meta;
  logic [1:0]       mode_sync;
  logic             step_req;
  logic [DIV_W-1:0] div_a;
  logic [CNT_W-1:0] cntr;
  logic [CNT_W-1:0] half_mask;
  logic             counting;
  logic             half_end;
  logic             rise_end;
  logic             fall_end;
  logic             clk_out_q;
  logic             rise_stb_q;
  logic [31:0]      tick_q;
  logic             busy_c;
  state_t           state;
  state_t           state_nxt;

  sm_deb_filter #(.DEB_CNT(DEB_CNT)) u_deb (
    .clk       (clkIn),
    .rst       (rst),
    .btn       (bus.stepBtn),
    .rise_pulse(step_req)
  );

  // Two-flop synchronisers for the divider and mode switches.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      dev_meta  <= '0;
      dev_sync  <= '0;
      mode_meta <= '0;
      mode_sync <= '0;
    end else begin
      dev_meta  <= bus.devide;
      dev_sync  <= dev_meta;
      mode_meta <= bus.mode;
      mode_sync <= mode_meta;
    end
  end

  // Mask of the low SHIFT+divA prescaler bits that make up one half-period.
  always_comb begin
    half_mask = '0;
    for (int i = 0; i < CNT_W; i++) begin
      if (i < SHIFT + int'(div_a)) half_mask[i] = 1'b1;
    end
  end

  assign counting = is_counting(state);
  assign half_end = counting && ((cntr & half_mask) == half_mask);
  assign rise_end = half_end && !clk_out_q;
  assign fall_end = half_end && clk_out_q;

  // Prescaler, output clock, rise strobe and CPU cycle counter.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      cntr       <= '0;
      clk_out_q  <= 1'b0;
      rise_stb_q <= 1'b0;
      tick_q     <= '0;
    end else begin
      rise_stb_q <= rise_end;
      if (!counting) begin
        cntr      <= '0;
        clk_out_q <= 1'b0;
      end else if (half_end) begin
        cntr      <= '0;
        clk_out_q <= ~clk_out_q;
      end else begin
        cntr <= cntr + CNT_W'(1);
      end
      if (rise_end) tick_q <= tick_q + 32'd1;
    end
  end

  // Divider ratio is only taken while stopped or at the end of a high half.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      div_a <= '0;
    end else if (state == S_STOP || fall_end) begin
      div_a <= dev_sync;
    end
  end

  // Mode state register.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) state <= S_STOP;
    else     state <= state_nxt;
  end

  // Next-state and busy decode; running modes only stop at the end of a full period.
  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    case (state)
      S_STOP: begin
        if (mode_sync == MODE_RUN) state_nxt = S_RUN;
        else if (step_req && mode_sync == MODE_STEP) state_nxt = S_STEP;
      end
      S_RUN: begin
        if (fall_end && mode_sync != MODE_RUN) state_nxt = S_STOP;
      end
      S_STEP: begin
        busy_c = 1'b1;
        if (fall_end) state_nxt = S_STOP;
      end
      default: state_nxt = S_STOP;
    endcase
  end

  assign bus.clkOut    = clk_out_q;
  assign bus.riseStb   = rise_stb_q;
  assign bus.tickCount = tick_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// tb_sm_clk_ctrl: scoreboard bench; stimulus queues expected clkOut edges, a monitor checks them.
module tb_sm_clk_ctrl;
  import sm_clk_pkg::*;

  typedef struct {
    logic rise;
    int   len;
    int   tick;
    logic busy;
  } ev_t;

  logic clkIn = 1'b0;
  logic rst   = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ev_t  expQ[$];
  logic prevClk = 1'b0;
  int   runLen  = 0;

  sm_clk_ctrl_if #(.DIV_W(2)) ifc ();

  sm_clk_ctrl #(
    .CNT_W  (8),
    .SHIFT  (1),
    .DIV_W  (2),
    .DEB_CNT(4)
  ) dut (
    .clkIn(clkIn),
    .rst  (rst),
    .bus  (ifc)
  );

  always #5 clkIn = ~clkIn;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [1:0] d, input logic b);
    ifc.mode    = m;
    ifc.devide  = d;
    ifc.stepBtn = b;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clkIn);
    #2;
  endtask

  task automatic pushEv(input logic r, input int l, input int t, input logic b);
    ev_t e;
    e.rise = r;
    e.len  = l;
    e.tick = t;
    e.busy = b;
    expQ.push_back(e);
  endtask

  // Monitor: on every clkOut transition pop the next expected edge and compare.
  always @(negedge clkIn) begin
    if (rst) begin
      prevClk = 1'b0;
      runLen  = 0;
    end else if (ifc.clkOut !== prevClk) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_edge", ifc.clkOut, prevClk);
      end else begin
        ev_t e;
        e = expQ.pop_front();
        checkOutput("edge_dir", ifc.clkOut, e.rise);
        if (e.len != 0) checkOutput("half_len", runLen, e.len);
        checkOutput("tick_at_edge", ifc.tickCount, e.tick);
        checkOutput("busy_at_edge", ifc.busy, e.busy);
        checkOutput("rise_stb", ifc.riseStb, ifc.clkOut);
      end
      prevClk = ifc.clkOut;
      runLen  = 1;
    end else begin
      runLen++;
      if (ifc.riseStb) checkOutput("stray_rise_stb", ifc.riseStb, 0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(MODE_STOP, 2'd0, 1'b0);
    waitCycles(3);
    checkOutput("reset_clkOut", ifc.clkOut, 0);
    checkOutput("reset_riseStb", ifc.riseStb, 0);
    checkOutput("reset_tick", ifc.tickCount, 0);
    checkOutput("reset_busy", ifc.busy, 0);
    rst = 1'b0;
    waitCycles(2);

    // Free-run at devide=0: 2-cycle halves, first rise 4 cycles after the switch.
    $display("[TB] run devide=0");
    applyStimulus(MODE_RUN, 2'd0, 1'b0);
    pushEv(1'b1, 0, 1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      pushEv(1'b0, 2, k, 1'b0);
      pushEv(1'b1, 2, k + 1, 1'b0);
    end
    waitCycles(22);
    checkOutput("run_high_before_rst", ifc.clkOut, 1);
    checkOutput("sb_drain_run", expQ.size(), 0);

    // Reset in the middle of a high half.
    $display("[TB] mid-run reset");
    rst = 1'b1;
    applyStimulus(MODE_STOP, 2'd0, 1'b0);
    #1;
    checkOutput("midrst_clkOut", ifc.clkOut, 0);
    checkOutput("midrst_tick", ifc.tickCount, 0);
    checkOutput("midrst_busy", ifc.busy, 0);
    checkOutput("midrst_riseStb", ifc.riseStb, 0);
    waitCycles(3);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      waitCycles(1);
      checkOutput("after_rst_clkOut", ifc.clkOut, 0);
      checkOutput("after_rst_tick", ifc.tickCount, 0);
    end

    // Ratio change 0 -> 3 inside a high half, then stop while high.
    $display("[TB] ratio change and stop");
    applyStimulus(MODE_RUN, 2'd0, 1'b0);
    pushEv(1'b1, 0, 1, 1'b0);
    pushEv(1'b0, 2, 1, 1'b0);
    pushEv(1'b1, 2, 2, 1'b0);
    pushEv(1'b0, 2, 2, 1'b0);
    pushEv(1'b1, 2, 3, 1'b0);
    pushEv(1'b0, 2, 3, 1'b0);
    pushEv(1'b1, 16, 4, 1'b0);
    pushEv(1'b0, 16, 4, 1'b0);
    pushEv(1'b1, 16, 5, 1'b0);
    pushEv(1'b0, 16, 5, 1'b0);
    waitCycles(9);
    checkOutput("ratio_switch_in_high", ifc.clkOut, 1);
    applyStimulus(MODE_RUN, 2'd3, 1'b0);
    waitCycles(55);
    checkOutput("stop_switch_in_high", ifc.clkOut, 1);
    applyStimulus(MODE_STOP, 2'd3, 1'b0);
    waitCycles(16);
    checkOutput("sb_drain_ratio", expQ.size(), 0);
    for (int k = 0; k < 20; k++) begin
      waitCycles(1);
      checkOutput("stopped_clkOut", ifc.clkOut, 0);
      checkOutput("stopped_tick", ifc.tickCount, 5);
    end

    // Clean single step at devide=1: 4 low, 4 high.
    $display("[TB] single step");
    applyStimulus(MODE_STEP, 2'd1, 1'b0);
    pushEv(1'b1, 0, 6, 1'b1);
    pushEv(1'b0, 4, 6, 1'b0);
    waitCycles(4);
    applyStimulus(MODE_STEP, 2'd1, 1'b1);
    waitCycles(6);
    checkOutput("step_busy_before", ifc.busy, 0);
    applyStimulus(MODE_STEP, 2'd1, 1'b0);
    waitCycles(1);
    checkOutput("step_busy_start", ifc.busy, 1);
    checkOutput("step_low_start", ifc.clkOut, 0);
    waitCycles(3);
    checkOutput("step_low_end", ifc.clkOut, 0);
    waitCycles(1);
    checkOutput("step_first_rise", ifc.clkOut, 1);
    checkOutput("step_tick_rise", ifc.tickCount, 6);
    waitCycles(16);
    checkOutput("step_done_clkOut", ifc.clkOut, 0);
    checkOutput("step_done_busy", ifc.busy, 0);
    checkOutput("step_done_tick", ifc.tickCount, 6);
    checkOutput("sb_drain_step", expQ.size(), 0);

    // Bouncing button: only the final stable press produces one step.
    $display("[TB] bouncing button");
    pushEv(1'b1, 0, 7, 1'b1);
    pushEv(1'b0, 4, 7, 1'b0);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(MODE_STEP, 2'd1, (k % 2 == 0) ? 1'b1 : 1'b0);
      checkOutput("bounce_busy", ifc.busy, 0);
      waitCycles(2);
    end
    applyStimulus(MODE_STEP, 2'd1, 1'b1);
    waitCycles(6);
    checkOutput("bounce_busy_before", ifc.busy, 0);
    waitCycles(1);
    checkOutput("bounce_busy_start", ifc.busy, 1);
    waitCycles(24);
    checkOutput("bounce_done_clkOut", ifc.clkOut, 0);
    checkOutput("bounce_done_busy", ifc.busy, 0);
    checkOutput("bounce_done_tick", ifc.tickCount, 7);
    checkOutput("sb_drain_bounce", expQ.size(), 0);
    applyStimulus(MODE_STOP, 2'd1, 1'b0);
    waitCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
